// File: rtl/dot_acc_pkg.sv
// dot_acc_pkg: shared width, state and product types for dot_accumulator
package dot_acc_pkg;
  localparam int PROD_W = 48;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} dot_acc_state_t;
  typedef logic [PROD_W-1:0] prod_t;
endpackage

// File: rtl/dot_accumulator.sv
// dot_accumulator: sums N_TERMS products into a dot product presented with valid/ack
// DOT_ACC_OVF_EN adds a sticky carry-out flag on port ovf
module dot_accumulator
  import dot_acc_pkg::*;
#(
  parameter int N_TERMS = 8,
  parameter int ACC_W = 54
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod,
  input  logic              clear,
  output logic              in_ready,
  output logic [7:0]        count,
  output logic [ACC_W-1:0]  sum,
  output logic              sum_valid,
  input  logic              sum_ack,
  output logic              drop
`ifdef DOT_ACC_OVF_EN
  ,
  output logic              ovf
`endif
);
  dot_acc_state_t state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, sum_nxt, base, add;
  logic [7:0] count_nxt, cnt_inc;
  logic take, done, release_h;
`ifdef DOT_ACC_OVF_EN
  logic carry;
`endif
  assign in_ready = state != HOLD;
  assign sum_valid = state == HOLD;
  // clear restarts the sum, so a product arriving with it becomes the first term
  always_comb begin
    take = prod_valid && state != HOLD;
    release_h = state == HOLD && sum_ack;
    base = clear ? '0 : acc;
`ifdef DOT_ACC_OVF_EN
    {carry, add} = {1'b0, base} + {{(ACC_W+1-PROD_W){1'b0}}, prod};
`else
    add = base + {{(ACC_W-PROD_W){1'b0}}, prod};
`endif
    cnt_inc = (clear ? 8'd0 : count) + 8'd1;
    done = cnt_inc == 8'(N_TERMS);
    state_nxt = take ? (done ? HOLD : ACCUM) : (clear || release_h) ? IDLE : state;
    acc_nxt = take ? add : (clear || release_h) ? '0 : acc;
    count_nxt = take ? cnt_inc : (clear || release_h) ? 8'd0 : count;
    sum_nxt = (take && done) ? add : sum;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      acc <= '0;
      count <= '0;
      sum <= '0;
      drop <= 1'b0;
`ifdef DOT_ACC_OVF_EN
      ovf <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      acc <= acc_nxt;
      count <= count_nxt;
      sum <= sum_nxt;
      drop <= !clear && (drop || (prod_valid && state == HOLD));
`ifdef DOT_ACC_OVF_EN
      ovf <= (ovf && !clear && !release_h) || (take && carry);
`endif
    end
  end
endmodule

// File: tb/tb_dot_accumulator.sv
// tb_dot_accumulator: three dot_accumulator configurations checked against a behavioural model each cycle
module tb_dot_accumulator;
  logic clk = 0, rst_n = 0, go = 0;
  logic pv[3], cl[3], ak[3];
  logic [47:0] pr[3];
  logic ir[3], sv[3], dr[3], ov[3];
  logic [7:0] d_cnt[3];
  logic [53:0] s0, s1;
  logic [47:0] s2;
  logic [63:0] d_sum[3];
  int checks = 0, errors = 0;
  int nt[3] = '{4, 1, 2};
  int aw[3] = '{54, 54, 48};
  logic [63:0] m_acc[3], m_sum[3];
  int m_cnt[3];
  bit m_hold[3], m_drop[3], m_ovf[3];

  always #5 clk = ~clk;

  assign d_sum[0] = 64'(s0);
  assign d_sum[1] = 64'(s1);
  assign d_sum[2] = 64'(s2);

  dot_accumulator #(.N_TERMS(4), .ACC_W(54)) dut4 (
    .clk(clk), .rst_n(rst_n), .prod_valid(pv[0]), .prod(pr[0]), .clear(cl[0]),
    .in_ready(ir[0]), .count(d_cnt[0]), .sum(s0), .sum_valid(sv[0]), .sum_ack(ak[0]), .drop(dr[0])
`ifdef DOT_ACC_OVF_EN
    , .ovf(ov[0])
`endif
  );
  dot_accumulator #(.N_TERMS(1), .ACC_W(54)) dut1 (
    .clk(clk), .rst_n(rst_n), .prod_valid(pv[1]), .prod(pr[1]), .clear(cl[1]),
    .in_ready(ir[1]), .count(d_cnt[1]), .sum(s1), .sum_valid(sv[1]), .sum_ack(ak[1]), .drop(dr[1])
`ifdef DOT_ACC_OVF_EN
    , .ovf(ov[1])
`endif
  );
  dot_accumulator #(.N_TERMS(2), .ACC_W(48)) dut48 (
    .clk(clk), .rst_n(rst_n), .prod_valid(pv[2]), .prod(pr[2]), .clear(cl[2]),
    .in_ready(ir[2]), .count(d_cnt[2]), .sum(s2), .sum_valid(sv[2]), .sum_ack(ak[2]), .drop(dr[2])
`ifdef DOT_ACC_OVF_EN
    , .ovf(ov[2])
`endif
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: terms are summed with full-width arithmetic and reduced modulo 2^ACC_W
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_acc[i] = 0; m_sum[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_drop[i] = 0; m_ovf[i] = 0;
      end else begin
        logic took;
        logic [64:0] full;
        logic [63:0] mask;
        mask = (64'd1 << aw[i]) - 64'd1;
        took = pv[i] && !m_hold[i];
        if (pv[i] && m_hold[i]) m_drop[i] = 1;
        if (cl[i]) begin
          m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_ovf[i] = 0; m_drop[i] = 0;
        end else if (m_hold[i] && ak[i]) begin
          m_acc[i] = 0; m_cnt[i] = 0; m_hold[i] = 0; m_ovf[i] = 0;
        end
        if (took) begin
          full = 65'(m_acc[i]) + 65'(pr[i]);
          if (full > 65'(mask)) m_ovf[i] = 1;
          m_acc[i] = full[63:0] & mask;
          m_cnt[i]++;
          if (m_cnt[i] == nt[i]) begin
            m_hold[i] = 1;
            m_sum[i] = m_acc[i];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (go) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("in_ready[%0d]", i), 64'(ir[i]), 64'(!m_hold[i]));
        chk($sformatf("sum_valid[%0d]", i), 64'(sv[i]), 64'(m_hold[i]));
        chk($sformatf("count[%0d]", i), 64'(d_cnt[i]), 64'(m_cnt[i]));
        chk($sformatf("sum[%0d]", i), d_sum[i], m_sum[i]);
        chk($sformatf("drop[%0d]", i), 64'(dr[i]), 64'(m_drop[i]));
`ifdef DOT_ACC_OVF_EN
        chk($sformatf("ovf[%0d]", i), 64'(ov[i]), 64'(m_ovf[i]));
`endif
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk) #1;
  endtask

  task automatic pulse(input int i, input logic [47:0] v);
    pv[i] = 1; pr[i] = v;
    cyc(1);
    pv[i] = 0;
  endtask

  task automatic ack(input int i);
    ak[i] = 1;
    cyc(1);
    ak[i] = 0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      pv[i] = 0; cl[i] = 0; ak[i] = 0; pr[i] = 0;
    end
    cyc(1);
    go = 1;
    cyc(2);
    chk("reset in_ready", 64'(ir[0]), 64'd1);
    chk("reset sum", d_sum[0], 64'd0);
    rst_n = 1;
    ak[0] = 1;
    cyc(1);
    ak[0] = 0;
    chk("ack in idle ignored", 64'(ir[0]), 64'd1);
    pulse(0, 48'd1); cyc(4);
    pulse(0, 48'd2); cyc(4);
    pulse(0, 48'd3); cyc(4);
    pulse(0, 48'hFFFF_FFFF_FFFF);
    chk("basic sum", d_sum[0], 64'h1_0000_0000_0005);
    chk("basic valid", 64'(sv[0]), 64'd1);
    cyc(3);
    chk("valid held", 64'(sv[0]), 64'd1);
    pulse(0, 48'h10);
    chk("backpressure drop", 64'(dr[0]), 64'd1);
    chk("backpressure sum", d_sum[0], 64'h1_0000_0000_0005);
    ack(0);
    chk("after ack valid", 64'(sv[0]), 64'd0);
    for (int k = 0; k < 4; k++) pulse(0, 48'd1);
    chk("back-to-back sum", d_sum[0], 64'd4);
    ack(0);
    pulse(0, 48'd1);
    pulse(0, 48'd1);
    cl[0] = 1; pv[0] = 1; pr[0] = 48'd7;
    cyc(1);
    cl[0] = 0; pv[0] = 0;
    chk("clear+prod count", 64'(d_cnt[0]), 64'd1);
    chk("clear drop", 64'(dr[0]), 64'd0);
    for (int k = 0; k < 3; k++) pulse(0, 48'd1);
    chk("clear+prod sum", d_sum[0], 64'd10);
    ack(0);
    pulse(1, 48'hABC);
    chk("n1 valid", 64'(sv[1]), 64'd1);
    chk("n1 sum", d_sum[1], 64'hABC);
    cl[1] = 1; ak[1] = 1;
    cyc(1);
    cl[1] = 0; ak[1] = 0;
    chk("n1 clear+ack valid", 64'(sv[1]), 64'd0);
    chk("n1 sum kept", d_sum[1], 64'hABC);
    pulse(2, 48'hFFFF_FFFF_FFFF);
    pulse(2, 48'd2);
    chk("wrap sum", d_sum[2], 64'd1);
`ifdef DOT_ACC_OVF_EN
    chk("ovf set", 64'(ov[2]), 64'd1);
`endif
    ack(0); ack(2);
    pulse(2, 48'd5);
    pulse(0, 48'd9);
    rst_n = 0;
    cyc(1);
    rst_n = 1;
    chk("mid reset count", 64'(d_cnt[0]), 64'd0);
    chk("mid reset valid", 64'(sv[0]), 64'd0);
`ifdef DOT_ACC_OVF_EN
    chk("mid reset ovf", 64'(ov[2]), 64'd0);
`endif
    cyc(3);
    go = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
